// File: rtl/risc_pipe_pkg.sv
// Shared pipeline typedefs for the RISC core: payload field encodings and the
// occupancy states of the elastic stage register.
package risc_pipe_pkg;

   typedef enum logic [2:0] {
      MEM_NONE = 3'd0,
      MEM_LB   = 3'd1,
      MEM_LH   = 3'd2,
      MEM_LW   = 3'd3,
      MEM_LBU  = 3'd4,
      MEM_LHU  = 3'd5,
      MEM_SB   = 3'd6,
      MEM_SW   = 3'd7
   } mem_op_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_CSR = 2'd3
   } wb_src_e;

   // Encoding doubles as the held-payload count.
   typedef enum logic [1:0] {
      STG_EMPTY = 2'd0,
      STG_ONE   = 2'd1,
      STG_FULL  = 2'd2
   } stage_state_e;

   function automatic logic [1:0] stage_occupancy(input stage_state_e s);
      case (s)
         STG_ONE:  return 2'd1;
         STG_FULL: return 2'd2;
         default:  return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry elastic pipeline register (main + skid slot) with registered
// in_ready, flush, and a saturating back-pressure cycle counter.
module pipe_stage_reg
   import risc_pipe_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   stage_state_e           state_q, state_d;
   logic                   in_ready_q, in_ready_d;
   logic [DATA_W-1:0]      main_q, main_d;
   logic [DATA_W-1:0]      skid_q, skid_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   accept;
   logic                   drain;

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      if (&v) return v;
      return v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign out_valid = (state_q != STG_EMPTY);
   assign in_ready  = in_ready_q;
   assign out_data  = main_q;
   assign occupancy = stage_occupancy(state_q);
   assign stall_cnt = stall_cnt_q;
   assign accept    = in_valid & in_ready_q;
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_d     = state_q;
      main_d      = main_q;
      skid_d      = skid_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         STG_EMPTY: begin
            if (accept) begin
               state_d = STG_ONE;
               main_d  = in_data;
            end
         end
         STG_ONE: begin
            if (accept && drain) begin
               main_d = in_data;
            end else if (accept) begin
               state_d = STG_FULL;
               skid_d  = in_data;
            end else if (drain) begin
               state_d = STG_EMPTY;
            end
         end
         STG_FULL: begin
            if (drain) begin
               state_d = STG_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = STG_EMPTY;
      endcase
      // A redirect discards everything, including a payload accepted this cycle.
      if (flush) begin
         state_d = STG_EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
      in_ready_d = (state_d != STG_FULL);
      if (out_valid && !out_ready) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= STG_EMPTY;
         in_ready_q  <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model, per-cycle compare,
// directed reset/stream/back-pressure/flush/saturation cases and random traffic.
module tb_pipe_stage_reg;

   logic        clk;
   logic        nrst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;

   logic        in_ready4;
   logic        out_valid4;
   logic [31:0] out_data4;
   logic [1:0]  occupancy4;
   logic [3:0]  stall_cnt4;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   pipe_stage_reg #(.DATA_W(32), .STALL_CNT_W(16)) dut (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.DATA_W(32), .STALL_CNT_W(4)) dut4 (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_data(in_data), .flush(flush), .out_valid(out_valid4),
      .out_ready(out_ready), .out_data(out_data4), .occupancy(occupancy4),
      .stall_cnt(stall_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the stage is a FIFO of at most two payloads.
   logic [31:0] q_m[$];
   logic [31:0] last_m   = '0;
   bit          ready_m  = 0;
   int unsigned stall_m  = 0;
   int unsigned stall4_m = 0;
   bit          acc_m, drn_m;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         q_m.delete();
         last_m   = '0;
         ready_m  = 0;
         stall_m  = 0;
         stall4_m = 0;
      end else begin
         acc_m = in_valid && ready_m;
         drn_m = (q_m.size() > 0) && out_ready;
         if (q_m.size() > 0 && !out_ready) begin
            if (stall_m < 65535) stall_m++;
            if (stall4_m < 15) stall4_m++;
         end
         if (flush) begin
            q_m.delete();
         end else begin
            if (drn_m) void'(q_m.pop_front());
            if (acc_m) q_m.push_back(in_data);
         end
         if (q_m.size() > 0) last_m = q_m[0];
         ready_m = (q_m.size() < 2);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, q_m.size() > 0);
         check("in_ready", in_ready, ready_m);
         check("occupancy", occupancy, q_m.size());
         check("out_data", out_data, last_m);
         check("stall_cnt", stall_cnt, stall_m);
         check("out_data_w4", out_data4, last_m);
         check("stall_cnt_w4", stall_cnt4, stall4_m);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nrst      = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hDEAD_BEEF;
      out_ready = 1'b0;
      flush     = 1'b0;
      #1;
      nrst = 1'b0;
      #1;
      chk_en = 1;
      // Reset takes effect without a clock edge.
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_occupancy", occupancy, 2'd0);
      check("rst_stall", stall_cnt, 16'd0);
      repeat (3) step();
      check("rst_hold_out_valid", out_valid, 1'b0);
      check("rst_hold_in_ready", in_ready, 1'b0);
      nrst = 1'b1;
      step();
      check("rel_in_ready", in_ready, 1'b1);
      check("rel_no_accept", out_valid, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();

      // Streaming at full rate.
      in_valid = 1'b1;
      in_data  = 32'h1;
      step();
      check("stream1_data", out_data, 32'h1);
      check("stream1_valid", out_valid, 1'b1);
      check("stream1_occ", occupancy, 2'd1);
      in_data = 32'h2;
      step();
      check("stream2_data", out_data, 32'h2);
      check("stream2_occ", occupancy, 2'd1);
      in_data = 32'h3;
      step();
      check("stream3_data", out_data, 32'h3);
      check("stream3_occ", occupancy, 2'd1);
      in_valid = 1'b0;
      step();
      check("stream_empty", occupancy, 2'd0);
      check("stream_no_stall", stall_cnt, 16'd0);

      // Back-pressure.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA;
      step();
      check("bp_a_data", out_data, 32'hA);
      in_data = 32'hB;
      step();
      check("bp_full_occ", occupancy, 2'd2);
      check("bp_full_ready", in_ready, 1'b0);
      check("bp_stall1", stall_cnt, 16'd1);
      in_data = 32'hC;
      step();
      check("bp_hold_data", out_data, 32'hA);
      check("bp_stall2", stall_cnt, 16'd2);
      step();
      check("bp_stall3", stall_cnt, 16'd3);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_drain_b", out_data, 32'hB);
      check("bp_drain_occ", occupancy, 2'd1);
      step();
      check("bp_done_valid", out_valid, 1'b0);
      check("bp_done_keep", out_data, 32'hB);
      check("bp_done_stall", stall_cnt, 16'd3);

      // Flush while FULL with a payload offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h11;
      step();
      in_data = 32'h22;
      step();
      check("fl_full_occ", occupancy, 2'd2);
      flush   = 1'b1;
      in_data = 32'h99;
      #1;
      check("fl_not_comb", out_valid, 1'b1);
      step();
      check("fl_empty_valid", out_valid, 1'b0);
      check("fl_empty_occ", occupancy, 2'd0);
      check("fl_ready", in_ready, 1'b1);
      check("fl_stall", stall_cnt, 16'd5);
      check("fl_keep", out_data, 32'h11);
      // Flush in ONE discards the same-cycle accepted payload.
      flush   = 1'b0;
      in_data = 32'h33;
      step();
      check("fl1_data", out_data, 32'h33);
      flush   = 1'b1;
      in_data = 32'h44;
      step();
      check("fl1_occ", occupancy, 2'd0);
      check("fl1_keep", out_data, 32'h33);
      flush    = 1'b0;
      in_valid = 1'b0;
      step();
      check("fl1_still_empty", out_valid, 1'b0);

      // Saturation of the narrow counter.
      in_valid = 1'b1;
      in_data  = 32'h55;
      step();
      in_valid = 1'b0;
      repeat (20) step();
      check("sat_w4", stall_cnt4, 4'hF);
      check("sat_w16", stall_cnt, 16'd26);
      check("sat_hold_data", out_data4, 32'h55);
      out_ready = 1'b1;
      step();

      // Random traffic with one asynchronous reset in the middle.
      for (int i = 0; i < 10000; i++) begin
         step();
         if (i == 5000) begin
            nrst = 1'b0;
            #1;
            check("mid_rst_valid", out_valid, 1'b0);
            check("mid_rst_data", out_data, 32'h0);
            check("mid_rst_occ", occupancy, 2'd0);
            check("mid_rst_stall", stall_cnt, 16'd0);
         end
         if (i == 5003) nrst = 1'b1;
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 65);
         flush     = ($urandom_range(0, 99) < 3);
         in_data   = $urandom;
      end
      step();
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
